// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Shared calculator constants and the reconstruct-checker state type.
// Rev    : 1.0
// ============================================================================
package calc_pkg;

  localparam int CALC_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } recon_state_t;

endpackage
`default_nettype wire

// File: rtl/div_reconstruct.sv
`default_nettype none
// ============================================================================
// Module : div_reconstruct
// Brief  : Rebuilds Q*B+R by shift-add (one quotient bit per clock) and checks
//          it against the dividend fed to the divider.
// Rev    : 1.0
// ============================================================================
module div_reconstruct
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   r,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   a_exp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] recon,
  output logic           match,
  output logic           err_rem,
  output logic           err_div0
);

  localparam int                 c_CNT_W    = $clog2(W);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(W - 1);

  recon_state_t       r_state;
  recon_state_t       w_state_next;
  logic [2*W-1:0]     r_acc;
  logic [2*W-1:0]     r_mb;
  logic [W-1:0]       r_mq;
  logic [W-1:0]       r_a_exp;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sh_rem;
  logic               r_sh_div0;
  logic               r_out_valid;
  logic [2*W-1:0]     r_recon;
  logic               r_match;
  logic               r_err_rem;
  logic               r_err_div0;

  logic [2*W-1:0]     w_acc_next;
  logic               w_last;
  logic               w_match;

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_mq[0] ? (r_acc + r_mb) : r_acc;
    w_last       = (r_cnt == c_CNT_LAST);
    // Any error flag vetoes a match even if the arithmetic happens to agree.
    w_match      = (w_acc_next == {{W{1'b0}}, r_a_exp}) && !(r_sh_rem || r_sh_div0);
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mb        <= '0;
      r_mq        <= '0;
      r_a_exp     <= '0;
      r_cnt       <= '0;
      r_sh_rem    <= 1'b0;
      r_sh_div0   <= 1'b0;
      r_out_valid <= 1'b0;
      r_recon     <= '0;
      r_match     <= 1'b0;
      r_err_rem   <= 1'b0;
      r_err_div0  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc     <= {{W{1'b0}}, r};
            r_mb      <= {{W{1'b0}}, b};
            r_mq      <= q;
            r_a_exp   <= a_exp;
            r_cnt     <= '0;
            r_sh_div0 <= (b == '0);
            r_sh_rem  <= (b != '0) && (r >= b);
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_mq  <= r_mq >> 1;
          r_mb  <= r_mb << 1;
          r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
          if (w_last) begin
            r_recon     <= w_acc_next;
            r_match     <= w_match;
            r_err_rem   <= r_sh_rem;
            r_err_div0  <= r_sh_div0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Result registers are deliberately left holding after the handshake.
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign recon     = r_recon;
  assign match     = r_match;
  assign err_rem   = r_err_rem;
  assign err_div0  = r_err_div0;

endmodule
`default_nettype wire
